// File: rtl/vdp_stream_if.sv
// Handshake bundle for the streaming dot-product engine: command, element stream and result.
interface vdp_stream_if #(
   parameter int N  = 8,
   parameter int M  = N,
   parameter int L  = 64,
   parameter int CW = 16
);
   logic                 start;
   logic [CW-1:0]        len;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [N-1:0]  a;
   logic signed [M-1:0]  b;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [L-1:0]  y;
   logic                 busy;

   modport master (
      output start, len, in_valid, a, b, out_ready,
      input  in_ready, out_valid, y, busy
   );

   modport slave (
      input  start, len, in_valid, a, b, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/vdp_stream.sv
// Streaming signed dot product: accumulates len element pairs, then presents the sum until taken.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// ACC   | accepting element pairs, accumulating a*b
// DONE  | result on y with out_valid until out_ready
module vdp_stream #(
   parameter int N  = 8,
   parameter int M  = N,
   parameter int L  = 64,
   parameter int CW = 16
) (
   input logic        clk,
   input logic        rst,
   vdp_stream_if.slave s
);
   localparam int P = N + M;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          state;
   logic signed [L-1:0] acc;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       len_q;
   logic [CW-1:0]       cnt_nxt;
   logic signed [P-1:0] prod;
   logic signed [L-1:0] prod_l;
   logic                accept;

   // Widen both operands to the full product width so the multiply keeps every bit.
   assign prod = $signed({{M{s.a[N-1]}}, s.a}) * $signed({{N{s.b[M-1]}}, s.b});

   generate
      if (L > P) begin : g_sext
         assign prod_l = {{(L-P){prod[P-1]}}, prod};
      end else if (L == P) begin : g_same
         assign prod_l = prod;
      end else begin : g_trunc
         assign prod_l = prod[L-1:0];
      end
   endgenerate

   assign cnt_nxt     = cnt + CW'(1);
   assign accept      = (state == S_ACC) && s.in_valid;

   assign s.in_ready  = (state == S_ACC);
   assign s.out_valid = (state == S_DONE);
   assign s.busy      = (state != S_IDLE);
   assign s.y         = (state == S_DONE) ? acc : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (s.start) begin
                  len_q <= s.len;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= (s.len == '0) ? S_DONE : S_ACC;
               end
            end
            S_ACC: begin
               if (accept) begin
                  acc <= acc + prod_l;
                  cnt <= cnt_nxt;
                  if (cnt_nxt == len_q) state <= S_DONE;
               end
            end
            S_DONE: begin
               // start in the handshake cycle is dropped: only IDLE looks at it.
               if (s.out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vdp_stream.sv
// Directed bench for vdp_stream: table of dot-product transactions plus corner-case sequences.
module tb_vdp_stream;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   vdp_stream_if #(.N(8), .M(8), .L(64), .CW(16)) vif ();
   vdp_stream_if #(.N(8), .M(8), .L(16), .CW(16)) vif16 ();

   assign vif16.start     = vif.start;
   assign vif16.len       = vif.len;
   assign vif16.in_valid  = vif.in_valid;
   assign vif16.a         = vif.a;
   assign vif16.b         = vif.b;
   assign vif16.out_ready = vif.out_ready;

   vdp_stream #(.N(8), .M(8), .L(64), .CW(16)) dut   (.clk(clk), .rst(rst), .s(vif));
   vdp_stream #(.N(8), .M(8), .L(16), .CW(16)) dut16 (.clk(clk), .rst(rst), .s(vif16));

   typedef struct {
      int               len;
      logic [3:0][7:0]  av;
      logic [3:0][7:0]  bv;
      int               gap;
      int               hold;
      logic [63:0]      y64;
      logic [15:0]      y16;
   } vec_t;

   vec_t tbl[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0][7:0] pk(input int a0, input int a1 = 0,
                                          input int a2 = 0, input int a3 = 0);
      logic [3:0][7:0] r;
      r[0] = 8'(a0);
      r[1] = 8'(a1);
      r[2] = 8'(a2);
      r[3] = 8'(a3);
      return r;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_txn(input string tag, input int len, input logic [3:0][7:0] av,
                          input logic [3:0][7:0] bv, input int gap, input int hold,
                          input logic [63:0] e64, input logic [15:0] e16);
      chk({tag, ".idle_busy"}, 64'(vif.busy), 64'd0);
      vif.start = 1'b1;
      vif.len   = 16'(len);
      @(negedge clk);
      vif.start = 1'b0;
      chk({tag, ".busy_after_start"}, 64'(vif.busy), 64'd1);
      for (int i = 0; i < len; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               vif.in_valid = 1'b0;
               vif.a = 8'h55;
               vif.b = 8'h55;
               @(negedge clk);
               chk({tag, ".stall_in_ready"}, 64'(vif.in_ready), 64'd1);
            end
         end
         chk({tag, ".in_ready"}, 64'(vif.in_ready), 64'd1);
         chk({tag, ".no_early_valid"}, 64'(vif.out_valid), 64'd0);
         vif.in_valid = 1'b1;
         vif.a = av[i];
         vif.b = bv[i];
         @(negedge clk);
      end
      vif.in_valid = 1'b0;
      chk({tag, ".out_valid"}, 64'(vif.out_valid), 64'd1);
      chk({tag, ".y64"}, vif.y, e64);
      chk({tag, ".y16"}, {48'd0, vif16.y}, {48'd0, e16});
      chk({tag, ".done_in_ready"}, 64'(vif.in_ready), 64'd0);
      for (int h = 0; h < hold; h++) begin
         vif.out_ready = 1'b0;
         @(negedge clk);
         chk({tag, ".hold_valid"}, 64'(vif.out_valid), 64'd1);
         chk({tag, ".hold_y"}, vif.y, e64);
      end
      vif.out_ready = 1'b1;
      @(negedge clk);
      vif.out_ready = 1'b0;
      chk({tag, ".post_valid"}, 64'(vif.out_valid), 64'd0);
      chk({tag, ".post_busy"}, 64'(vif.busy), 64'd0);
      chk({tag, ".post_y"}, vif.y, 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{len:3, av:pk(2, -4, 7), bv:pk(3, 5, -1), gap:0, hold:0,
                 y64:64'(-21), y16:16'(-21)};
      tbl[1] = '{len:4, av:pk(1, 2, 3, 4), bv:pk(1, 2, 3, 4), gap:2, hold:5,
                 y64:64'd30, y16:16'd30};
      tbl[2] = '{len:2, av:pk(-128, -128), bv:pk(-128, -128), gap:0, hold:1,
                 y64:64'd32768, y16:16'h8000};
      tbl[3] = '{len:1, av:pk(127), bv:pk(-128), gap:1, hold:0,
                 y64:64'(-16256), y16:16'(-16256)};
      tbl[4] = '{len:4, av:pk(127, 127, 127, 127), bv:pk(127, 127, 127, 127), gap:0, hold:2,
                 y64:64'd64516, y16:16'hFC04};

      rst = 1'b0;
      vif.start = 1'b0;
      vif.len = '0;
      vif.in_valid = 1'b0;
      vif.a = '0;
      vif.b = '0;
      vif.out_ready = 1'b0;
      #3;
      chk("reset.busy", 64'(vif.busy), 64'd0);
      chk("reset.in_ready", 64'(vif.in_ready), 64'd0);
      chk("reset.out_valid", 64'(vif.out_valid), 64'd0);
      chk("reset.y", vif.y, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 5; k++)
         run_txn($sformatf("vec%0d", k), tbl[k].len, tbl[k].av, tbl[k].bv,
                 tbl[k].gap, tbl[k].hold, tbl[k].y64, tbl[k].y16);

      // zero length goes straight to DONE with y=0
      vif.start = 1'b1;
      vif.len = 16'd0;
      @(negedge clk);
      vif.start = 1'b0;
      chk("zero.out_valid", 64'(vif.out_valid), 64'd1);
      chk("zero.y", vif.y, 64'd0);
      chk("zero.in_ready", 64'(vif.in_ready), 64'd0);
      chk("zero.busy", 64'(vif.busy), 64'd1);
      vif.out_ready = 1'b1;
      @(negedge clk);
      vif.out_ready = 1'b0;
      chk("zero.post_busy", 64'(vif.busy), 64'd0);
      chk("zero.post_in_ready", 64'(vif.in_ready), 64'd0);

      // reset in the middle of accumulation
      vif.start = 1'b1;
      vif.len = 16'd5;
      @(negedge clk);
      vif.start = 1'b0;
      vif.in_valid = 1'b1;
      vif.a = 8'sd10;
      vif.b = 8'sd10;
      @(negedge clk);
      @(negedge clk);
      vif.in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rstmid.in_ready", 64'(vif.in_ready), 64'd0);
      chk("rstmid.busy", 64'(vif.busy), 64'd0);
      chk("rstmid.out_valid", 64'(vif.out_valid), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid.wait_start", 64'(vif.busy), 64'd0);
      run_txn("rstmid_new", 1, pk(3), pk(4), 0, 0, 64'd12, 16'd12);

      // start pulses during ACC and during the DONE handshake are ignored
      vif.start = 1'b1;
      vif.len = 16'd2;
      @(negedge clk);
      vif.start = 1'b0;
      vif.in_valid = 1'b1;
      vif.a = 8'sd5;
      vif.b = 8'sd6;
      @(negedge clk);
      vif.in_valid = 1'b0;
      vif.start = 1'b1;
      vif.len = 16'd3;
      @(negedge clk);
      vif.start = 1'b0;
      chk("coll.acc_busy", 64'(vif.busy), 64'd1);
      chk("coll.acc_in_ready", 64'(vif.in_ready), 64'd1);
      vif.in_valid = 1'b1;
      vif.a = -8'sd2;
      vif.b = 8'sd3;
      @(negedge clk);
      vif.in_valid = 1'b0;
      chk("coll.out_valid", 64'(vif.out_valid), 64'd1);
      chk("coll.y", vif.y, 64'd24);
      vif.out_ready = 1'b1;
      vif.start = 1'b1;
      vif.len = 16'd1;
      @(negedge clk);
      vif.out_ready = 1'b0;
      vif.start = 1'b0;
      chk("coll.idle_busy", 64'(vif.busy), 64'd0);
      chk("coll.idle_valid", 64'(vif.out_valid), 64'd0);
      chk("coll.idle_in_ready", 64'(vif.in_ready), 64'd0);
      @(negedge clk);
      @(negedge clk);
      chk("coll.stays_idle", 64'(vif.busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
